mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Third pipeline stage of the three-stage RV32I core. It registers the execute-stage result, waits for the data-memory response on loads, and performs load-data alignment and sign extension. It selects the register-file write-back value and drives the write port. It also keeps the one- and two-instruction history (instruction and data) that execute-stage forwarding consumes, and owns the tohost CSR and the optional cycle/instret counters.

## Interface
- `XLEN`, default 32: datapath width.
- `NOP_INST`, default 32'h0000_0013: encoding loaded into the stage and history registers on reset and bubble.
- `clk` in 1: core clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `x_valid` in 1: the execute stage offers an instruction. Low means bubble, including flush.
- `x_inst` in 32: instruction in execute.
- `x_pc` in 32: PC of that instruction.
- `x_alu` in 32: ALU result. This is the memory address for loads and stores.
- `x_rs1_data` in 32: forwarded rs1 value, used by csrw.
- `x_stall` out 1: stage holding. The execute stage and everything upstream must freeze.
- `dmem_resp_valid` in 1: `dmem_rdata` is valid this cycle.
- `dmem_rdata` in 32: raw word read from data memory.
- `wb_we` out 1: register-file write enable.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: write-back value.
- `mem_wb_inst` out 32: instruction currently in this stage, for execute-stage forwarding.
- `prev_prev_inst` out 32: previous occupant of this stage.
- `prev_prev_data` out 32: `wb_data` of that previous occupant.
- `csr_tohost` out 32: tohost CSR (0x51E).

## Operation
- **Stage register**
  - Fields: inst, pc, alu, rs1_data, valid.
  - Loaded on every edge where `x_stall` = 0.
  - `x_valid` = 0 loads `NOP_INST` with valid = 0.
- **FSM states**
  - ACCEPT: the current occupant retires this cycle.
  - WAIT_MEM: the occupant is a load and `dmem_resp_valid` = 0.
- **FSM outputs and transitions**
  - `x_stall` = 1 exactly while in WAIT_MEM. The stage register, history and counters hold.
  - WAIT_MEM is left in the first cycle with `dmem_resp_valid` = 1. That cycle retires.
- **Write-back select**, by opcode of the stage register:
  - LUI, AUIPC, R-type, I-type: `alu`.
  - JAL, JALR: `pc + 4`.
  - LOAD: extracted data.
  - CSR read of a counter: the counter value.
  - STORE, BRANCH, and csrw/csrwi of tohost: no write.
- **Write enable**
  - `wb_we` = valid & writes-rd & rd ≠ 0 & not stalled.
  - `wb_rd` is inst[11:7].
- **Load extraction**, with off = alu[1:0]:
  - LB / LBU: byte `off`, sign- or zero-extended.
  - LH / LHU: half `off[1]`, sign- or zero-extended. off[0] is ignored.
  - LW: full word; `off` is ignored.
- **tohost**
  - csrw (funct3 001) to 0x51E writes `rs1_data`.
  - csrwi (funct3 101) to 0x51E writes zero-extended inst[19:15].
  - Written on the retire edge only.
- **History**: on every non-stalled edge, `prev_prev_inst` ← `mem_wb_inst` and `prev_prev_data` ← `wb_data`. Bubbles shift in as `NOP_INST`.
- **Retire**: an instruction retires on the first non-stalled edge while it is valid.

## Timing
- **Reset values**
  - Stage inst and `prev_prev_inst`: `NOP_INST`.
  - valid, `prev_prev_data`, `csr_tohost`, counters: 0.
  - `wb_we`, `x_stall`: 0.
  - FSM: ACCEPT.
- **Latency**
  - An instruction enters on edge N and writes back combinationally in cycle N.
  - The register file captures the write at edge N+1.
  - A load adds k cycles, where k is the number of cycles `dmem_resp_valid` stays low.
- **Memory handshake**
  - `dmem_rdata` is sampled only in a cycle where the occupant is a load and `dmem_resp_valid` = 1.
  - `dmem_resp_valid` is ignored for non-loads.
- **Boundary cases**
  - A flush arriving while stalled has no effect until the stall ends; the held load still retires.
  - Back-to-back loads each wait independently.
  - Reset mid-WAIT_MEM returns to ACCEPT and discards the load.

## Configuration
- Macro: `MEM_WB_COUNTERS_EN`.
- **Defined**
  - 64-bit `cycle` counter: increments every cycle out of reset, including stall cycles.
  - 64-bit `instret` counter: increments on each retire of a valid, non-bubble instruction.
  - CSR reads (csrrs/csrrc with rs1 = x0) of 0xC00/0xC80 return the cycle counter low/high half; 0xC02/0xC82 return the instret counter low/high half.
- **Undefined**: no counter registers exist; those reads write 0 to rd.

## Structure
- **Shared package**: opcode and funct3 constants (`OPC_*`, `FNC_*`), CSR address constants (tohost, cycle, instret and their high halves), `NOP_INST`.
- **Sub-module**: `load_extract`, combinational; inputs funct3, off and rdata, output the aligned 32-bit value.
- FSM, stage register, history, tohost and counters stay in `mem_wb_stage`.

## Test plan
- **lb with sign extension**: lb with alu = 0x1002, rdata = 0x80FF_1234, resp in the same cycle → `wb_data` = 0xFFFF_FFFF, `wb_we` = 1, `x_stall` = 0.
- **lhu with delayed response**: lhu with alu = 0x1002, rdata = 0xBEEF_0000, resp delayed 2 cycles → `x_stall` high for exactly 2 cycles, then `wb_data` = 0x0000_BEEF.
- **jal**: jal with rd = x1, pc = 0x100 → `wb_data` = 0x104. Then sw → `wb_we` = 0.
- **tohost**: csrw 0x51E with rs1_data = 1 → `csr_tohost` = 1 the next cycle. Then csrwi 0x51E, zimm = 5 → `csr_tohost` = 5.
- **Forwarding history**: three addi instructions writing x5 = 7, x6 = 9, x7 = 1 → after the third enters, `mem_wb_inst` = addi x7, `prev_prev_inst` = addi x6, `prev_prev_data` = 9. A bubble shifts in `NOP_INST`.
- **Counters** (`MEM_WB_COUNTERS_EN` defined): 10 cycles containing 4 instructions and 6 bubbles, then csrr 0xC02 → `wb_data` = 4. With the macro undefined → 0. Separately, assert reset in WAIT_MEM → `x_stall` = 0 immediately.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared constants for the memory/write-back stage.
//   OPC_*  : RV32I major opcodes decoded by the stage
//   FNC_*  : load and CSR funct3 encodings
//   CSR_*  : tohost and counter CSR addresses
//   NOP_INST : addi x0, x0, 0, loaded on reset and bubble
//   mem_wb_state_e : stage FSM states
package mem_wb_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FNC_LB     = 3'b000;
  localparam logic [2:0] FNC_LH     = 3'b001;
  localparam logic [2:0] FNC_LW     = 3'b010;
  localparam logic [2:0] FNC_LBU    = 3'b100;
  localparam logic [2:0] FNC_LHU    = 3'b101;
  localparam logic [2:0] FNC_CSRRW  = 3'b001;
  localparam logic [2:0] FNC_CSRRS  = 3'b010;
  localparam logic [2:0] FNC_CSRRC  = 3'b011;
  localparam logic [2:0] FNC_CSRRWI = 3'b101;

  localparam logic [11:0] CSR_TOHOST   = 12'h51E;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    ST_ACCEPT,
    ST_WAIT_MEM
  } mem_wb_state_e;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: combinational load-data alignment and sign extension.
//   funct3 : load funct3 (LB/LH/LW/LBU/LHU)
//   off    : byte offset, address[1:0]
//   rdata  : raw word from data memory
//   aligned: value to write back
module load_extract
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] aligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = rdata[{off, 3'b000} +: 8];
    // Halfword selection ignores off[0]; misaligned halves read the aligned half.
    w_half  = off[1] ? rdata[31:16] : rdata[15:0];
    aligned = rdata;
    case (funct3)
      FNC_LB:  aligned = {{(XLEN-8){w_byte[7]}}, w_byte};
      FNC_LBU: aligned = XLEN'(w_byte);
      FNC_LH:  aligned = {{(XLEN-16){w_half[15]}}, w_half};
      FNC_LHU: aligned = XLEN'(w_half);
      FNC_LW:  aligned = rdata;
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-response / write-back stage of the 3-stage RV32I core.
// Registers the execute result, stalls loads until dmem_resp_valid, aligns
// load data, drives the register-file write port, keeps a two-deep
// instruction/data history for forwarding and owns the tohost CSR.
// Optional build macro MEM_WB_COUNTERS_EN adds 64-bit cycle/instret counters.
// Ports:
//   clk, reset                : clock, async active-high reset
//   x_valid/x_inst/x_pc/x_alu/x_rs1_data : execute-stage offer
//   x_stall                   : freeze upstream stages
//   dmem_resp_valid/dmem_rdata: data-memory response
//   wb_we/wb_rd/wb_data       : register-file write port
//   mem_wb_inst, prev_prev_inst, prev_prev_data : forwarding history
//   csr_tohost                : tohost CSR (0x51E)
module mem_wb_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INST = mem_wb_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            x_valid,
  input  logic [31:0]     x_inst,
  input  logic [XLEN-1:0] x_pc,
  input  logic [XLEN-1:0] x_alu,
  input  logic [XLEN-1:0] x_rs1_data,
  output logic            x_stall,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     mem_wb_inst,
  output logic [31:0]     prev_prev_inst,
  output logic [XLEN-1:0] prev_prev_data,
  output logic [XLEN-1:0] csr_tohost
);
  import mem_wb_stage_pkg::*;

  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_pc, r_alu, r_rs1;
  logic            r_valid;
  logic [31:0]     r_pp_inst;
  logic [XLEN-1:0] r_pp_data, r_tohost;

  mem_wb_state_e   r_state, w_state_nxt;
  logic            w_stall;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [11:0]     w_csr;
  logic            w_cnt_rd, w_tohost_wr, w_writes_rd;
  logic [XLEN-1:0] w_tohost_val, w_load_data, w_cnt_data, w_wb_data;

  // ST_WAIT_MEM is entered when a load is captured and held until its
  // response arrives, so a same-cycle response retires without stalling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACCEPT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCEPT:   w_stall = 1'b0;
      ST_WAIT_MEM: w_stall = !dmem_resp_valid;
      default:     w_stall = 1'b0;
    endcase
    if (!w_stall)
      w_state_nxt = (x_valid && x_inst[6:0] == OPC_LOAD) ? ST_WAIT_MEM : ST_ACCEPT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst  <= NOP_INST;
      r_pc    <= '0;
      r_alu   <= '0;
      r_rs1   <= '0;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      if (x_valid) begin
        r_inst  <= x_inst;
        r_pc    <= x_pc;
        r_alu   <= x_alu;
        r_rs1   <= x_rs1_data;
        r_valid <= 1'b1;
      end else begin
        r_inst  <= NOP_INST;
        r_pc    <= '0;
        r_alu   <= '0;
        r_rs1   <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .funct3  (r_inst[14:12]),
    .off     (r_alu[1:0]),
    .rdata   (dmem_rdata),
    .aligned (w_load_data)
  );

`ifdef MEM_WB_COUNTERS_EN
  logic [63:0] r_cycle, r_instret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (!w_stall && r_valid) r_instret <= r_instret + 64'd1;
    end
  end

  always_comb begin
    w_cnt_data = '0;
    case (w_csr)
      CSR_CYCLE:    w_cnt_data = XLEN'(r_cycle[31:0]);
      CSR_CYCLEH:   w_cnt_data = XLEN'(r_cycle[63:32]);
      CSR_INSTRET:  w_cnt_data = XLEN'(r_instret[31:0]);
      CSR_INSTRETH: w_cnt_data = XLEN'(r_instret[63:32]);
      default:      w_cnt_data = '0;
    endcase
  end
`else
  always_comb w_cnt_data = '0;
`endif

  always_comb begin
    w_opc        = r_inst[6:0];
    w_f3         = r_inst[14:12];
    w_csr        = r_inst[31:20];
    w_cnt_rd     = (w_opc == OPC_SYSTEM) && (w_f3 == FNC_CSRRS || w_f3 == FNC_CSRRC) &&
                   (r_inst[19:15] == 5'd0) &&
                   (w_csr == CSR_CYCLE || w_csr == CSR_CYCLEH ||
                    w_csr == CSR_INSTRET || w_csr == CSR_INSTRETH);
    w_tohost_wr  = (w_opc == OPC_SYSTEM) && (w_f3 == FNC_CSRRW || w_f3 == FNC_CSRRWI) &&
                   (w_csr == CSR_TOHOST);
    w_tohost_val = (w_f3 == FNC_CSRRWI) ? XLEN'(r_inst[19:15]) : r_rs1;
    // Non-writing instructions present zero so the history is deterministic.
    w_writes_rd  = 1'b0;
    w_wb_data    = '0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: begin
        w_writes_rd = 1'b1;
        w_wb_data   = r_alu;
      end
      OPC_JAL, OPC_JALR: begin
        w_writes_rd = 1'b1;
        w_wb_data   = r_pc + XLEN'(4);
      end
      OPC_LOAD: begin
        w_writes_rd = 1'b1;
        w_wb_data   = w_load_data;
      end
      OPC_SYSTEM: begin
        w_writes_rd = w_cnt_rd;
        w_wb_data   = w_cnt_rd ? w_cnt_data : '0;
      end
      default: begin
        w_writes_rd = 1'b0;
        w_wb_data   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pp_inst <= NOP_INST;
      r_pp_data <= '0;
      r_tohost  <= '0;
    end else if (!w_stall) begin
      r_pp_inst <= r_inst;
      r_pp_data <= w_wb_data;
      if (r_valid && w_tohost_wr) r_tohost <= w_tohost_val;
    end
  end

  assign x_stall        = w_stall;
  assign wb_we          = r_valid && w_writes_rd && (r_inst[11:7] != 5'd0) && !w_stall;
  assign wb_rd          = r_inst[11:7];
  assign wb_data        = w_wb_data;
  assign mem_wb_inst    = r_inst;
  assign prev_prev_inst = r_pp_inst;
  assign prev_prev_data = r_pp_data;
  assign csr_tohost     = r_tohost;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized checks of mem_wb_stage against a
// behavioural reference model of the stage's retire/write-back rules.
module tb_mem_wb_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        x_valid;
  logic [31:0] x_inst, x_pc, x_alu, x_rs1_data;
  logic        x_stall;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_wb_inst, prev_prev_inst, prev_prev_data, csr_tohost;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .x_valid         (x_valid),
    .x_inst          (x_inst),
    .x_pc            (x_pc),
    .x_alu           (x_alu),
    .x_rs1_data      (x_rs1_data),
    .x_stall         (x_stall),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .mem_wb_inst     (mem_wb_inst),
    .prev_prev_inst  (prev_prev_inst),
    .prev_prev_data  (prev_prev_data),
    .csr_tohost      (csr_tohost)
  );

  int unsigned n_pass, n_fail, n_total;

  // Reference model: current occupant, history, tohost, counters.
  logic [31:0] m_inst, m_pc, m_alu, m_rs1;
  logic        m_valid;
  logic [31:0] m_pp_inst, m_pp_data, m_tohost;
  logic [63:0] m_cycle, m_instret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_inst = NOP; m_pc = '0; m_alu = '0; m_rs1 = '0; m_valid = 1'b0;
    m_pp_inst = NOP; m_pp_data = '0; m_tohost = '0;
    m_cycle = '0; m_instret = '0;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned off = a % 4;
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic is_cnt_read(input logic [31:0] inst);
    logic [11:0] c = inst[31:20];
    return inst[6:0] == 7'h73 && (inst[14:12] == 3'd2 || inst[14:12] == 3'd3) &&
           inst[19:15] == 5'd0 &&
           (c == 12'hC00 || c == 12'hC80 || c == 12'hC02 || c == 12'hC82);
  endfunction

  function automatic logic [31:0] ref_counter(input logic [11:0] c);
`ifdef MEM_WB_COUNTERS_EN
    case (c)
      12'hC00: return m_cycle[31:0];
      12'hC80: return m_cycle[63:32];
      12'hC02: return m_instret[31:0];
      12'hC82: return m_instret[63:32];
      default: return 32'h0;
    endcase
`else
    return (c == 12'hFFF) ? 32'h1 : 32'h0;
`endif
  endfunction

  function automatic logic ref_writes(input logic [31:0] inst);
    case (inst[6:0])
      7'h37, 7'h17, 7'h33, 7'h13, 7'h6F, 7'h67, 7'h03: return 1'b1;
      default: return is_cnt_read(inst);
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] inst, input logic [31:0] pc,
                                           input logic [31:0] alu, input logic [31:0] rdata);
    case (inst[6:0])
      7'h37, 7'h17, 7'h33, 7'h13: return alu;
      7'h6F, 7'h67:               return pc + 32'd4;
      7'h03:                      return ref_load(inst[14:12], alu, rdata);
      7'h73:                      return is_cnt_read(inst) ? ref_counter(inst[31:20]) : 32'h0;
      default:                    return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rs1,
                       input logic resp, input logic [31:0] rdata);
    x_valid = v; x_inst = inst; x_pc = pc; x_alu = alu; x_rs1_data = rs1;
    dmem_resp_valid = resp; dmem_rdata = rdata;
  endtask

  // Mid-cycle comparison of all outputs against the model.
  task automatic mid_checks();
    logic stall_e, we_e;
    #4;
    stall_e = m_valid && m_inst[6:0] == 7'h03 && !dmem_resp_valid;
    we_e    = m_valid && ref_writes(m_inst) && m_inst[11:7] != 5'd0 && !stall_e;
    check("x_stall", 32'(x_stall), 32'(stall_e));
    check("wb_we", 32'(wb_we), 32'(we_e));
    check("wb_rd", 32'(wb_rd), 32'(m_inst[11:7]));
    if (!stall_e) check("wb_data", wb_data, ref_data(m_inst, m_pc, m_alu, dmem_rdata));
    check("mem_wb_inst", mem_wb_inst, m_inst);
    check("prev_prev_inst", prev_prev_inst, m_pp_inst);
    check("prev_prev_data", prev_prev_data, m_pp_data);
    check("csr_tohost", csr_tohost, m_tohost);
  endtask

  task automatic tick();
    logic stall_e;
    logic [31:0] d;
    stall_e = m_valid && m_inst[6:0] == 7'h03 && !dmem_resp_valid;
    d = ref_data(m_inst, m_pc, m_alu, dmem_rdata);
    @(posedge clk);
    if (reset) model_reset();
    else begin
      m_cycle++;
      if (!stall_e) begin
        if (m_valid) begin
          if (m_inst[6:0] == 7'h73 && m_inst[31:20] == 12'h51E) begin
            if (m_inst[14:12] == 3'b001)      m_tohost = m_rs1;
            else if (m_inst[14:12] == 3'b101) m_tohost = {27'd0, m_inst[19:15]};
          end
          m_instret++;
        end
        m_pp_inst = m_inst;
        m_pp_data = d;
        if (x_valid) begin
          m_inst = x_inst; m_pc = x_pc; m_alu = x_alu; m_rs1 = x_rs1_data; m_valid = 1'b1;
        end else begin
          m_inst = NOP; m_pc = '0; m_alu = '0; m_rs1 = '0; m_valid = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] rs1,
                      input logic resp, input logic [31:0] rdata);
    drive(v, inst, pc, alu, rs1, resp, rdata);
    mid_checks();
    tick();
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  task automatic rand_inst(output logic [31:0] w);
    int unsigned k = $urandom_range(0, 11);
    w = $urandom();
    case (k)
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h33;
      3: w[6:0] = 7'h13;
      4: w[6:0] = 7'h6F;
      5: w[6:0] = 7'h67;
      6: begin
        w[6:0] = 7'h03;
        case ($urandom_range(0, 4))
          0: w[14:12] = 3'd0;
          1: w[14:12] = 3'd1;
          2: w[14:12] = 3'd2;
          3: w[14:12] = 3'd4;
          default: w[14:12] = 3'd5;
        endcase
      end
      7: w[6:0] = 7'h23;
      8: w[6:0] = 7'h63;
      9:  w = {12'h51E, w[19:15], 3'b001, 5'd0, 7'h73};
      10: w = {12'h51E, w[19:15], 3'b101, 5'd0, 7'h73};
      default: begin
        case ($urandom_range(0, 3))
          0: w[31:20] = 12'hC00;
          1: w[31:20] = 12'hC80;
          2: w[31:20] = 12'hC02;
          default: w[31:20] = 12'hC82;
        endcase
        w[19:15] = 5'd0;
        w[14:12] = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
        w[6:0]   = 7'h73;
      end
    endcase
  endtask

  initial begin
    logic [31:0] ri;
    logic [31:0] lb_i, lhu_i, lw_i, lbu_i, jal_i, sw_i, csrw_i, csrwi_i, csrr_i;
    n_pass = 0; n_fail = 0; n_total = 0;
    lb_i    = {12'h0, 5'd1, 3'b000, 5'd3, 7'h03};
    lhu_i   = {12'h0, 5'd1, 3'b101, 5'd4, 7'h03};
    lw_i    = {12'h0, 5'd1, 3'b010, 5'd8, 7'h03};
    lbu_i   = {12'h0, 5'd1, 3'b100, 5'd9, 7'h03};
    jal_i   = {20'h0, 5'd1, 7'h6F};
    sw_i    = {7'h0, 5'd2, 5'd1, 3'b010, 5'h0, 7'h23};
    csrw_i  = {12'h51E, 5'd2, 3'b001, 5'd0, 7'h73};
    csrwi_i = {12'h51E, 5'd5, 3'b101, 5'd0, 7'h73};
    csrr_i  = {12'hC02, 5'd0, 3'b010, 5'd10, 7'h73};

    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_x_stall", 32'(x_stall), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_mem_wb_inst", mem_wb_inst, NOP);
    check("rst_prev_prev_inst", prev_prev_inst, NOP);
    check("rst_prev_prev_data", prev_prev_data, 32'd0);
    check("rst_tohost", csr_tohost, 32'd0);
    reset = 1'b0;

    // Counters: 4 instructions among 10 cycles, then read instret.
    for (int i = 0; i < 10; i++)
      step(i % 3 == 0, addi(5'd1, 12'd3), 32'h0, 32'd3, 32'h0, 1'b0, 32'h0);
    step(1'b1, csrr_i, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
`ifdef MEM_WB_COUNTERS_EN
    check("instret_read", wb_data, 32'd4);
`else
    check("instret_read", wb_data, 32'd0);
`endif
    check("instret_we", 32'(wb_we), 32'd1);
    tick();

    // lb with same-cycle response.
    step(1'b1, lb_i, 32'h200, 32'h1002, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h80FF_1234);
    mid_checks();
    check("lb_data", wb_data, 32'hFFFF_FFFF);
    check("lb_we", 32'(wb_we), 32'd1);
    check("lb_stall", 32'(x_stall), 32'd0);
    tick();

    // lhu with 2-cycle delayed response; flushes offered during the stall.
    step(1'b1, lhu_i, 32'h204, 32'h1002, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      mid_checks();
      check("lhu_stall", 32'(x_stall), 32'd1);
      tick();
    end
    drive(1'b1, addi(5'd2, 12'd1), 32'h208, 32'd1, 32'h0, 1'b1, 32'hBEEF_0000);
    mid_checks();
    check("lhu_stall_end", 32'(x_stall), 32'd0);
    check("lhu_data", wb_data, 32'h0000_BEEF);
    check("lhu_we", 32'(wb_we), 32'd1);
    tick();

    // jal then sw.
    step(1'b1, jal_i, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, sw_i, 32'h104, 32'h2000, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("jal_data", wb_data, 32'h104);
    check("jal_we", 32'(wb_we), 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    mid_checks();
    check("sw_we", 32'(wb_we), 32'd0);
    tick();

    // tohost via csrw then csrwi.
    step(1'b1, csrw_i, 32'h300, 32'h0, 32'd1, 1'b0, 32'h0);
    drive(1'b1, csrwi_i, 32'h304, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("tohost_csrw", csr_tohost, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("tohost_csrwi", csr_tohost, 32'd5);
    tick();

    // Forwarding history.
    step(1'b1, addi(5'd5, 12'd7), 32'h400, 32'd7, 32'h0, 1'b0, 32'h0);
    step(1'b1, addi(5'd6, 12'd9), 32'h404, 32'd9, 32'h0, 1'b0, 32'h0);
    step(1'b1, addi(5'd7, 12'd1), 32'h408, 32'd1, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("hist_cur", mem_wb_inst, addi(5'd7, 12'd1));
    check("hist_prev", prev_prev_inst, addi(5'd6, 12'd9));
    check("hist_prev_data", prev_prev_data, 32'd9);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("hist_bubble_cur", mem_wb_inst, NOP);
    check("hist_bubble_prev", prev_prev_inst, addi(5'd7, 12'd1));
    check("hist_bubble_data", prev_prev_data, 32'd1);
    tick();

    // Back-to-back loads, each waiting one cycle.
    step(1'b1, lw_i, 32'h500, 32'h3001, 32'h0, 1'b0, 32'h0);
    drive(1'b1, lbu_i, 32'h504, 32'h3003, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("b2b_stall1", 32'(x_stall), 32'd1);
    tick();
    drive(1'b1, lbu_i, 32'h504, 32'h3003, 32'h0, 1'b1, 32'h1122_3344);
    mid_checks();
    check("b2b_lw_data", wb_data, 32'h1122_3344);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("b2b_stall2", 32'(x_stall), 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA5B6_C7D8);
    mid_checks();
    check("b2b_lbu_data", wb_data, 32'h0000_00A5);
    tick();

    // Reset while waiting on memory.
    step(1'b1, lw_i, 32'h600, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    mid_checks();
    check("rstwait_stall_before", 32'(x_stall), 32'd1);
    reset = 1'b1;
    #1;
    check("rstwait_stall", 32'(x_stall), 32'd0);
    check("rstwait_we", 32'(wb_we), 32'd0);
    check("rstwait_inst", mem_wb_inst, NOP);
    model_reset();
    tick();
    reset = 1'b0;

    // Randomized stream.
    for (int i = 0; i < 400; i++) begin
      rand_inst(ri);
      step($urandom_range(0, 3) != 0, ri, $urandom(), $urandom(), $urandom(),
           $urandom_range(0, 1) == 1, $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
